// File: rtl/prediction_queue_pkg.sv
// Shared branch-prediction types: the RV32I machine word and the in-flight
// prediction entry recorded by fetch.
`timescale 1ns/1ps
package prediction_queue_pkg;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    rv32i_word pc;
    rv32i_word pred_next_pc;
  } pred_entry_t;

endpackage

// File: rtl/prediction_queue.sv
// In-order queue of predicted control-flow instructions. It checks each
// execute resolution against the recorded prediction and drives the
// predictor update / fetch redirect port.
`timescale 1ns/1ps
module prediction_queue
  import prediction_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  rv32i_word                push_pc,
  input  rv32i_word                push_pred_next_pc,
  output logic                     push_ready,
  input  logic                     resolve_valid,
  input  rv32i_word                resolve_next_pc,
  input  logic                     flush,
  output logic                     predict_en,
  output logic                     predictionFailed,
  output rv32i_word                resolved_pc,
  output rv32i_word                expected_next_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     resolve_error
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  pred_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  pred_entry_t      head_entry;
  logic             do_resolve;
  logic             mispredict;
  logic             clear_q;
  logic             push_accept;

  always_comb begin
    head_entry  = mem[head];
    push_ready  = (count < DEPTH_C) || resolve_valid;
    do_resolve  = resolve_valid && (count != '0);
    mispredict  = do_resolve && (resolve_next_pc != head_entry.pred_next_pc);
    // A mispredict or flush empties the queue, so a same-cycle push is lost.
    clear_q     = flush || mispredict;
    push_accept = push_valid && push_ready && !clear_q;
  end

  // Entry storage is never reset; validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[tail] <= '{pc: push_pc, pred_next_pc: push_pred_next_pc};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      predict_en       <= 1'b0;
      predictionFailed <= 1'b0;
      resolved_pc      <= '0;
      expected_next_pc <= '0;
      resolve_error    <= 1'b0;
    end else begin
      predict_en       <= do_resolve;
      predictionFailed <= mispredict;
      if (do_resolve) begin
        resolved_pc      <= head_entry.pc;
        expected_next_pc <= resolve_next_pc;
      end
      if (resolve_valid && (count == '0)) begin
        resolve_error <= 1'b1;
      end
      if (clear_q) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (push_accept) tail <= tail + PTR_W'(1);
        if (do_resolve)  head <= head + PTR_W'(1);
        count <= count + CNT_W'(push_accept) - CNT_W'(do_resolve);
      end
    end
  end

endmodule
